// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register slice.
// Optional feature macro: ID_EX_MULT_STALL_EN (multi-cycle MULTU holding).
package id_ex_stage_pkg;

    // Control bundle widths
    localparam int EX_W  = 4;   // {RegDst, ALUOp[1:0], ALUSrc}
    localparam int MEM_W = 3;   // {MemRead, MemWrite, MemtoReg}
    localparam int WB_W  = 2;   // {RegWrite, MemtoReg}

    // Bundle bit positions
    localparam int MEM_READ_BIT  = 2;
    localparam int REG_WRITE_BIT = 1;

    // Decode values used to recognise MULTU
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

    // EX occupancy state
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MULT = 1'b1
    } state_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
// A load into $0 never creates a hazard.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu
);

    // A valid load in EX whose destination is read by the valid ID instruction
    always_comb begin
        lu = ex_valid & ex_memread & (ex_rt != 5'd0) & id_valid &
             ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, flush and, when the macro
// ID_EX_MULT_STALL_EN is defined, a multi-cycle hold for MULTU.
// Without the macro MULTU is an ordinary single-cycle instruction.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int MULT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [EX_W-1:0]   id_ex,
    input  logic [MEM_W-1:0]  id_mem,
    input  logic [WB_W-1:0]   id_wb,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_shamt,
    output logic              ex_valid,
    output logic [EX_W-1:0]   ex_ex,
    output logic [MEM_W-1:0]  ex_mem,
    output logic [WB_W-1:0]   ex_wb,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_shamt,
    output logic              stall,
    output logic              ex_hold
);

    logic lu;
    logic hold;
    logic bubble;

    hazard_detect u_hazard_detect (
        .ex_valid   (ex_valid),
        .ex_memread (ex_mem[MEM_READ_BIT]),
        .ex_rt      (ex_rt),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .lu         (lu)
    );

`ifdef ID_EX_MULT_STALL_EN
    localparam logic [5:0] CNT_LOAD = 6'(MULT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [5:0] cnt;
    logic [5:0] cnt_next;
    logic       id_is_multu;

    // EX is occupied while a MULTU still has cycles left to run
    always_comb begin
        hold        = (state == ST_MULT) && (cnt != 6'd0);
        id_is_multu = id_valid && (id_ex[2:1] == ALUOP_RTYPE) &&
                      (id_funct == FUNCT_MULTU);
    end

    // Next state: flush aborts, hold counts down, bubbles return to RUN,
    // a normal load starts a new multiply when the incoming op is MULTU
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush) begin
            state_next = ST_RUN;
            cnt_next   = 6'd0;
        end else if (hold) begin
            cnt_next   = cnt - 6'd1;
        end else if (lu) begin
            state_next = ST_RUN;
            cnt_next   = 6'd0;
        end else if (id_is_multu) begin
            state_next = ST_MULT;
            cnt_next   = CNT_LOAD;
        end else begin
            state_next = ST_RUN;
            cnt_next   = 6'd0;
        end
    end

    // State and down-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= 6'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end
`else
    // Without multi-cycle support EX is never held
    always_comb begin
        hold = 1'b0;
    end
`endif

    // Hazard-side outputs and the bubble decision for this edge
    always_comb begin
        ex_hold = hold;
        stall   = hold | (lu & ~hold);
        bubble  = flush | (~hold & lu);
    end

    // Pipeline register: bubble zeroes valid and controls, hold freezes
    // everything, otherwise the ID contents move into EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ex      <= '0;
            ex_mem     <= '0;
            ex_wb      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_funct   <= '0;
            ex_shamt   <= '0;
        end else if (bubble) begin
            ex_valid   <= 1'b0;
            ex_ex      <= '0;
            ex_mem     <= '0;
            ex_wb      <= '0;
        end else if (!hold) begin
            ex_valid   <= id_valid;
            ex_ex      <= id_ex;
            ex_mem     <= id_mem;
            ex_wb      <= id_wb;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_funct   <= id_funct;
            ex_shamt   <= id_shamt;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations plus randomized traffic checked against a cycle-level model.
// Honours ID_EX_MULT_STALL_EN the same way the design does.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int MC = 4;
`ifdef ID_EX_MULT_STALL_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif
    localparam logic [3:0] ADD_EX = 4'b1100;
    localparam logic [5:0] ADD_FN = 6'b100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_ex = '0;
    logic [2:0]  id_mem = '0;
    logic [1:0]  id_wb = '0;
    logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, id_shamt = '0;
    logic [5:0]  id_funct = '0;
    logic        ex_valid;
    logic [3:0]  ex_ex;
    logic [2:0]  ex_mem;
    logic [1:0]  ex_wb;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [5:0]  ex_funct;
    logic        stall, ex_hold;

    int passCount = 0;
    int checkCount = 0;
    bit chkEn = 1'b0;

    // Model of what EX must contain, plus remaining held cycles of a MULTU
    logic        mValid;
    logic [3:0]  mEx;
    logic [2:0]  mMem;
    logic [1:0]  mWb;
    logic [31:0] mRsD, mRtD, mImm;
    logic [4:0]  mRs, mRt, mRd, mShamt;
    logic [5:0]  mFunct;
    int          mBusy;

    id_ex_stage #(.MULT_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_ex(id_ex), .id_mem(id_mem), .id_wb(id_wb),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_funct(id_funct), .id_shamt(id_shamt),
        .ex_valid(ex_valid), .ex_ex(ex_ex), .ex_mem(ex_mem), .ex_wb(ex_wb),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .ex_shamt(ex_shamt),
        .stall(stall), .ex_hold(ex_hold)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    function automatic bit modelLu();
        return mValid && mMem[2] && (mRt != 5'd0) && id_valid &&
               ((mRt == id_rs) || (mRt == id_rt));
    endfunction

    function automatic bit modelBusy();
        return MULT_EN && (mBusy > 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input bit f, input bit v, input logic [3:0] e,
                                 input logic [2:0] m, input logic [1:0] w,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [5:0] fn);
        flush      = f;
        id_valid   = v;
        id_ex      = e;
        id_mem     = m;
        id_wb      = w;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_funct   = fn;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm     = $urandom;
        id_shamt   = 5'($urandom);
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 4'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0);
    endtask

    // Reference model: advance one edge from the rules, cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid = 0; mEx = 0; mMem = 0; mWb = 0;
            mRsD = 0; mRtD = 0; mImm = 0;
            mRs = 0; mRt = 0; mRd = 0; mShamt = 0; mFunct = 0;
            mBusy = 0;
        end else begin
            if (flush) begin
                mValid = 0; mEx = 0; mMem = 0; mWb = 0; mBusy = 0;
            end else if (modelBusy()) begin
                mBusy = mBusy - 1;
            end else if (modelLu()) begin
                mValid = 0; mEx = 0; mMem = 0; mWb = 0; mBusy = 0;
            end else begin
                mValid = id_valid; mEx = id_ex; mMem = id_mem; mWb = id_wb;
                mRsD = id_rs_data; mRtD = id_rt_data; mImm = id_imm;
                mRs = id_rs; mRt = id_rt; mRd = id_rd;
                mFunct = id_funct; mShamt = id_shamt;
                mBusy = (id_valid && id_ex[2:1] == 2'b10 && id_funct == 6'd25)
                        ? MC - 1 : 0;
            end
        end
    end

    // Every cycle out of reset the DUT must match the model
    always @(negedge clk) begin
        if (chkEn && rst_n) begin
            checkOutput("m_stall", 32'(stall), 32'(modelBusy() || modelLu()));
            checkOutput("m_ex_hold", 32'(ex_hold), 32'(modelBusy()));
            checkOutput("m_ex_valid", 32'(ex_valid), 32'(mValid));
            checkOutput("m_ex_ex", 32'(ex_ex), 32'(mEx));
            checkOutput("m_ex_mem", 32'(ex_mem), 32'(mMem));
            checkOutput("m_ex_wb", 32'(ex_wb), 32'(mWb));
            if (mValid) begin
                checkOutput("m_rs_data", ex_rs_data, mRsD);
                checkOutput("m_rt_data", ex_rt_data, mRtD);
                checkOutput("m_imm", ex_imm, mImm);
                checkOutput("m_regs", {17'd0, ex_rs, ex_rt, ex_rd},
                            {17'd0, mRs, mRt, mRd});
                checkOutput("m_funct_shamt", {21'd0, ex_funct, ex_shamt},
                            {21'd0, mFunct, mShamt});
            end
        end
    end

    initial begin
        // Reset held for three cycles under random inputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 4'($urandom), 3'($urandom),
                          2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                          6'($urandom));
            @(negedge clk);
            checkOutput("rst_valid", 32'(ex_valid), 0);
            checkOutput("rst_ctrl", {23'd0, ex_ex, ex_mem, ex_wb}, 0);
            checkOutput("rst_data", ex_rs_data | ex_rt_data | ex_imm, 0);
            checkOutput("rst_fields", {11'd0, ex_rs, ex_rt, ex_rd, ex_funct, ex_shamt}, 0);
            checkOutput("rst_stall", 32'(stall), 0);
            checkOutput("rst_hold", 32'(ex_hold), 0);
            nextEdge();
        end
        idle();
        rst_n = 1'b1;
        chkEn = 1'b1;
        nextEdge();

        // Load-use: lw $5 then add reading $5
        applyStimulus(0, 1, 4'b0001, 3'b101, 2'b11, 5'd1, 5'd5, 5'd0, 6'd0);
        nextEdge();
        applyStimulus(0, 1, ADD_EX, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, ADD_FN);
        @(negedge clk);
        checkOutput("lu_stall", 32'(stall), 1);
        nextEdge();
        @(negedge clk);
        checkOutput("lu_bubble_valid", 32'(ex_valid), 0);
        checkOutput("lu_bubble_stall", 32'(stall), 0);
        nextEdge();
        idle();
        @(negedge clk);
        checkOutput("lu_add_valid", 32'(ex_valid), 1);
        checkOutput("lu_add_rs", 32'(ex_rs), 5);
        nextEdge();

        // Load into $0 never stalls
        applyStimulus(0, 1, 4'b0001, 3'b101, 2'b11, 5'd0, 5'd0, 5'd0, 6'd0);
        nextEdge();
        applyStimulus(0, 1, ADD_EX, 3'b000, 2'b10, 5'd0, 5'd0, 5'd9, ADD_FN);
        @(negedge clk);
        checkOutput("zero_stall", 32'(stall), 0);
        nextEdge();
        idle();
        @(negedge clk);
        checkOutput("zero_valid", 32'(ex_valid), 1);
        checkOutput("zero_rd", 32'(ex_rd), 9);
        nextEdge();

        // MULTU followed by an independent add
        applyStimulus(0, 1, ADD_EX, 3'b000, 2'b10, 5'd2, 5'd3, 5'd0, FUNCT_MULTU);
        nextEdge();
        applyStimulus(0, 1, ADD_EX, 3'b000, 2'b10, 5'd9, 5'd10, 5'd11, ADD_FN);
`ifdef ID_EX_MULT_STALL_EN
        for (int c = 1; c < MC; c++) begin
            @(negedge clk);
            checkOutput("mul_stall", 32'(stall), 1);
            checkOutput("mul_hold", 32'(ex_hold), 1);
            checkOutput("mul_funct", 32'(ex_funct), 32'(FUNCT_MULTU));
            nextEdge();
        end
        @(negedge clk);
        checkOutput("mul_last_stall", 32'(stall), 0);
        checkOutput("mul_last_hold", 32'(ex_hold), 0);
        checkOutput("mul_last_funct", 32'(ex_funct), 32'(FUNCT_MULTU));
        nextEdge();
`else
        @(negedge clk);
        checkOutput("mul1_hold", 32'(ex_hold), 0);
        checkOutput("mul1_stall", 32'(stall), 0);
        nextEdge();
`endif
        idle();
        @(negedge clk);
        checkOutput("mul_next_funct", 32'(ex_funct), 32'(ADD_FN));
        checkOutput("mul_next_rs", 32'(ex_rs), 9);
        nextEdge();

        // Flush on the second cycle of a MULTU that also reads as a load
        applyStimulus(0, 1, ADD_EX, 3'b100, 2'b00, 5'd2, 5'd3, 5'd0, FUNCT_MULTU);
        nextEdge();
        applyStimulus(0, 1, ADD_EX, 3'b000, 2'b10, 5'd3, 5'd4, 5'd8, ADD_FN);
        @(negedge clk);
        checkOutput("fl_c1_stall", 32'(stall), 1);
        nextEdge();
        applyStimulus(1, 1, ADD_EX, 3'b000, 2'b10, 5'd3, 5'd4, 5'd8, ADD_FN);
`ifdef ID_EX_MULT_STALL_EN
        @(negedge clk);
        checkOutput("fl_c2_stall", 32'(stall), 1);
        checkOutput("fl_c2_hold", 32'(ex_hold), 1);
`endif
        nextEdge();
        idle();
        @(negedge clk);
        checkOutput("fl_valid", 32'(ex_valid), 0);
        checkOutput("fl_ctrl", {23'd0, ex_ex, ex_mem, ex_wb}, 0);
        checkOutput("fl_hold", 32'(ex_hold), 0);
        checkOutput("fl_stall", 32'(stall), 0);
        nextEdge();

        // Reset asserted in the middle of a MULTU clears at once
        applyStimulus(0, 1, ADD_EX, 3'b000, 2'b11, 5'd4, 5'd6, 5'd12, FUNCT_MULTU);
        nextEdge();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_valid", 32'(ex_valid), 0);
        checkOutput("mrst_hold", 32'(ex_hold), 0);
        checkOutput("mrst_stall", 32'(stall), 0);
        checkOutput("mrst_fields", {15'd0, ex_funct, ex_rd, ex_wb, ex_ex}, 0);
        nextEdge();
        nextEdge();
        rst_n = 1'b1;
        nextEdge();

        // Randomized traffic biased toward hazards, MULTU and flushes
        for (int i = 0; i < 2000; i++) begin
            logic [5:0] fn;
            logic [3:0] e;
            fn = ($urandom_range(0, 4) == 0) ? FUNCT_MULTU : 6'($urandom);
            e  = 4'($urandom);
            if (fn == FUNCT_MULTU && $urandom_range(0, 3) != 0) e[2:1] = 2'b10;
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0,
                          e, 3'($urandom), 2'($urandom),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom), fn);
            nextEdge();
        end

        idle();
        nextEdge();
        chkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The module SHALL have parameter MULT_CYCLES, default 32, giving the number of cycles a MULTU occupies EX (legal range 2..63).
REQ-002 The module SHALL use one clock and an asynchronous, active-low reset. These are fixed.
REQ-003 The ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- flush  in  1  squash the instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_ex  in  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_mem  in  3  {MemRead, MemWrite, MemtoReg}
- id_wb  in  2  {RegWrite, MemtoReg}
- id_rs_data, id_rt_data, id_imm  in  32 each  operands and sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register numbers
- id_funct  in  6  function field
- id_shamt  in  5  shift amount
- ex_valid, ex_ex, ex_mem, ex_wb, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct, ex_shamt  out  registered copies, same widths
- stall  out  1  hold PC and IF/ID this cycle
- ex_hold  out  1  EX occupied; EX/MEM shall take a bubble

Function
REQ-004 A load-use hazard (lu) SHALL be: ex_valid & ex_mem[2] & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt). It is combinational.
REQ-005 The FSM SHALL have states RUN and MULT, plus a 6-bit down-counter cnt.
REQ-006 Per-edge priority SHALL be: flush > hold > lu bubble > normal load.
REQ-007 Hold condition: state == MULT and cnt != 0. While held, all ex_* registers SHALL keep their values and cnt SHALL decrement by 1.
REQ-008 Bubble and flush SHALL both load ex_valid=0 and all control bundles as 0 (never X). Data fields are don't-care.
REQ-009 Normal load SHALL copy every id_* field into ex_* on the next edge, with ex_valid=id_valid. Latency is 1 cycle.
REQ-010 If a loaded instruction has id_valid=1, id_ex[2:1]=2'b10 and id_funct=6'b011001 (MULTU), then state SHALL go to MULT and cnt SHALL be set to MULT_CYCLES-1. Otherwise state SHALL go to RUN.
REQ-011 In MULT with cnt == 0, the stage SHALL behave as RUN for that cycle, including loading a new MULTU back-to-back.
REQ-012 stall SHALL equal hold | (lu & !hold). ex_hold SHALL equal hold. Both are combinational from registered state.
REQ-013 A MULTU SHALL occupy EX for exactly MULT_CYCLES cycles, with stall=1 for MULT_CYCLES-1 of them.
REQ-014 flush during MULT SHALL abort the multiply: state goes to RUN, cnt to 0, and a bubble is loaded.
REQ-015 flush and lu in the same cycle SHALL load a bubble with stall=1 (lu still holds IF/ID).
REQ-016 The module SHALL not compare against register 0: a lw to $0 SHALL never stall.

Reset
REQ-017 While rst_n=0, the block SHALL asynchronously force ex_valid=0, all ex_* fields to 0, state to RUN and cnt to 0. stall and ex_hold SHALL read 0.
REQ-018 Reset deassertion SHALL take effect at the first following clk edge. No operation resumes after reset mid-MULT.

Configuration
REQ-019 With macro ID_EX_MULT_STALL_EN defined, MULTU multi-cycle holding SHALL behave as in REQ-007 to REQ-014.
REQ-020 Without ID_EX_MULT_STALL_EN, state SHALL stay RUN, cnt SHALL be absent, MULTU SHALL be a 1-cycle instruction, ex_hold SHALL be constant 0, and stall SHALL equal lu.

Structure
REQ-021 The shared package SHALL hold the bundle widths (EX=4, MEM=3, WB=2), the bundle bit indices (MemRead=2, RegWrite=1), the ALUOp R-type code 2'b10, the MULTU funct code 6'b011001, and the state encodings.
REQ-022 Load-use detection SHALL be a separate combinational sub-module, hazard_detect. The register, FSM and counter SHALL stay in id_ex_stage.

Verification
REQ-023 Reset: hold rst_n=0 for 3 cycles with random inputs -> all ex_*=0, stall=0, ex_hold=0. Assert mid-MULT -> immediate clear.
REQ-024 Load-use: lw $5 (ex_mem=3'b101, ex_rt=5) then ID add with id_rs=5 -> stall=1 for one cycle and ex_valid=0 next. The add then enters with ex_rs=5.
REQ-025 Zero register: lw $0 then an ID instruction using rs=0 -> stall=0, no bubble.
REQ-026 MULTU, MULT_CYCLES=4: load MULTU -> ex_* stable 4 cycles, stall=1 for 3 cycles, ex_hold=1 for 3 cycles. A following add then loads on the 4th edge.
REQ-027 Flush priority: flush=1 on the 2nd MULT cycle with lu also true -> ex_valid=0, controls 0, state RUN, and stall stays 1 only for lu.
REQ-028 Macro off: rebuild without ID_EX_MULT_STALL_EN, load MULTU -> ex_hold=0, and the next instruction loads on the next edge.
